// File: rtl/sqrt_iter.sv
// Iterative restoring integer square root, floor or round-to-nearest.
// Define SQRT_ITER_SKIP_EN to skip leading zero bit pairs via an ALIGN step.
module sqrt_iter #(
  parameter int WIDTH = 70
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] value,
  input  logic             round_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH/2-1:0] root,
  output logic [WIDTH/2:0] rem,
  output logic             nx,
  output logic             sat,
  output logic             busy
);

  localparam int RW = WIDTH / 2;

`ifdef SQRT_ITER_SKIP_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    CALC  = 2'd2,
    DONE  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;
`endif

  state_t state_q, state_d;

  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] bit_q;
  logic             rnd_q;

  logic [WIDTH:0]   trial;
  logic             take;
  logic [RW-1:0]    flr;
  logic [RW:0]      inc;
  logic             up;

  assign trial = {1'b0, acc_q} + {1'b0, bit_q};
  assign take  = {1'b0, res_q} >= trial;
  assign flr   = acc_q[RW-1:0];
  assign inc   = {1'b0, flr} + (RW+1)'(1);
  assign up    = rnd_q && (res_q > acc_q);

  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;

`ifdef SQRT_ITER_SKIP_EN
  // One-hot at the lowest bit of the highest nonzero bit pair.
  function automatic logic [WIDTH-1:0] top_pair(
    input logic [WIDTH-1:0] v
  );
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < RW; i++)
      if (v[2*i +: 2] != 2'b00)
        r = WIDTH'(1) << (2 * i);
    return r;
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (!nreset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid)
`ifdef SQRT_ITER_SKIP_EN
          state_d = ALIGN;
`else
          state_d = CALC;
`endif
      end
`ifdef SQRT_ITER_SKIP_EN
      ALIGN: state_d = CALC;
`endif
      CALC: begin
        if (bit_q == '0) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      res_q <= '0;
      acc_q <= '0;
      bit_q <= '0;
      rnd_q <= 1'b0;
      root  <= '0;
      rem   <= '0;
      nx    <= 1'b0;
      sat   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            res_q <= value;
            acc_q <= '0;
            rnd_q <= round_en;
`ifdef SQRT_ITER_SKIP_EN
            bit_q <= '0;
`else
            bit_q <= WIDTH'(1) << (WIDTH - 2);
`endif
          end
        end
`ifdef SQRT_ITER_SKIP_EN
        ALIGN: bit_q <= top_pair(res_q);
`endif
        CALC: begin
          if (bit_q != '0) begin
            if (take) begin
              res_q <= res_q - trial[WIDTH-1:0];
              acc_q <= (acc_q >> 1) + bit_q;
            end else begin
              acc_q <= acc_q >> 1;
            end
            bit_q <= bit_q >> 2;
          end else begin
            // Rounding never wraps: an all-ones root stays put and flags sat.
            rem <= res_q[RW:0];
            nx  <= res_q != '0;
            if (up && inc[RW]) begin
              root <= flr;
              sat  <= 1'b1;
            end else if (up) begin
              root <= inc[RW-1:0];
              sat  <= 1'b0;
            end else begin
              root <= flr;
              sat  <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sqrt_iter.md
SQRT_ITER -- requirements
Module: sqrt_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 70: radicand width; even, >= 4.
REQ-002 SHALL have localparam RW = WIDTH/2: root width.
REQ-003 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-004 SHALL have port nreset  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  operand offered.
REQ-006 SHALL have port in_ready  output  1  block idle, can accept.
REQ-007 SHALL have port value  input  WIDTH  unsigned radicand.
REQ-008 SHALL have port round_en  input  1  1 = round to nearest, 0 = floor.
REQ-009 SHALL have port out_valid  output  1  result held valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port root  output  RW  result root.
REQ-012 SHALL have port rem  output  RW+1  value - floor_root^2.
REQ-013 SHALL have port nx  output  1  inexact, rem != 0.
REQ-014 SHALL have port sat  output  1  rounding saturated root.
REQ-015 SHALL have port busy  output  1  state != IDLE.

Function
REQ-016 SHALL use states IDLE, ALIGN (macro only), CALC, DONE.
REQ-017 SHALL assert in_ready only in IDLE; accept on rising edge with in_valid && in_ready, capturing value and round_en.
REQ-018 SHALL ignore value/round_en changes after acceptance.
REQ-019 SHALL compute restoring digit-by-digit: bit pair from MSB pair down; per CALC cycle, if residue >= acc+bit, subtract and set acc=(acc>>1)+bit, else acc=acc>>1; bit>>=2.
REQ-020 SHALL on bit==0 in CALC take one finishing edge: floor root=acc[RW-1:0], rem=residue, nx=(rem!=0), enter DONE.
REQ-021 SHALL with round_en=1 increment root when rem > floor root; rem and nx still refer to floor root.
REQ-022 SHALL saturate rounded root at 2^RW-1 and set sat=1 when increment overflows; otherwise sat=0.
REQ-023 SHALL in DONE hold out_valid=1 and root/rem/nx/sat stable until out_ready=1 on an edge, then return to IDLE.
REQ-024 SHALL keep in_ready=0 in DONE; no accept on the same edge as out_ready handoff.
REQ-025 SHALL keep root/rem/nx/sat at last value outside DONE; only out_valid qualifies them.

Reset
REQ-026 SHALL on clock edge with nreset=0 go to IDLE, out_valid=0, root=0, rem=0, nx=0, sat=0, busy=0, in_ready=1.
REQ-027 SHALL abort an operation in progress on reset, no out_valid produced; first post-reset accept behaves as fresh.

Configuration
REQ-028 SHALL honour macro SQRT_ITER_SKIP_EN.
REQ-029 SHALL without macro start CALC at bit = 2^(WIDTH-2); out_valid rises exactly RW+1 edges after the accepting edge, for every value.
REQ-030 SHALL with macro insert one ALIGN edge that loads bit with the highest nonzero bit pair of value via priority encode (value 0: bit=0); out_valid rises k+2 edges after accept, k = floor(msb/2)+1, k=0 for value 0.
REQ-031 SHALL produce identical root/rem/nx/sat in both configurations.

Verification (WIDTH=16)
REQ-032 SHALL test value=144, round_en=0 -> root=12, rem=0, nx=0, sat=0; no macro: out_valid 9 edges after accept.
REQ-033 SHALL test value=150, round_en=0 -> root=12, rem=6, nx=1; value=157, round_en=1 -> root=13, rem=13, nx=1.
REQ-034 SHALL test value=65535, round_en=1 -> root=255, rem=510, nx=1, sat=1; round_en=0 -> root=255, sat=0.
REQ-035 SHALL test value=0 -> root=0, rem=0, nx=0; with macro out_valid 2 edges after accept.
REQ-036 SHALL test out_ready held 0 for 5 cycles -> outputs stable, in_ready=0, in_valid ignored; out_ready=1 -> IDLE next edge.
REQ-037 SHALL test nreset=0 mid-CALC -> IDLE, out_valid=0 next edge; following accept of 144 -> root=12.
